// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AddrWidth = 16;
    localparam int unsigned DataWidth = 16;

    localparam int unsigned P_FETCH = 0;
    localparam int unsigned P_DATA  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake between the two ports and the memory arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic [1:0]           req;
    logic [1:0]           we;
    logic [AddrWidth-1:0] addr0;
    logic [AddrWidth-1:0] addr1;
    logic [DataWidth-1:0] wdata0;
    logic [DataWidth-1:0] wdata1;
    logic [DataWidth-1:0] rdata;
    logic [1:0]           ack;
    logic                 err;
    logic                 busy;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        output rdata, ack, err, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is chosen.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    always_comb begin
        idx_o = 1'(P_FETCH);
        case (req_i)
            2'b10:   idx_o = 1'(P_DATA);
            2'b11:   idx_o = ~last_grant_i;
            default: idx_o = 1'(P_FETCH);
        endcase
        gnt_o = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-port requests onto a shared single-port memory with a
// tristate data bus, inserting a turnaround cycle after every access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_arbiter_if.slave         bus,
    output logic [AddrWidth-1:0] mem_addr,
    output logic                 mem_load,
    output logic                 mem_ctrl,
    inout  wire  [DataWidth-1:0] mem_bus
);

    localparam logic [3:0] WaitLast = 4'(WAIT_STATES);

    state_e               state_q;
    logic                 last_grant_q;
    logic                 idx_q;
    logic                 we_q;
    logic                 oor_q;
    logic [3:0]           wcnt_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] rdata_q;
    logic [1:0]           ack_q;
    logic                 err_q;
    logic                 busy_q;
    logic                 load_q;
    logic                 ctrl_q;
    logic                 drive_q;

    logic [1:0]           gnt;
    logic                 gnt_idx;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic                 sel_we;
    logic                 sel_oor;

    rr_arbiter2 u_rr (
        .req_i        (bus.req),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .idx_o        (gnt_idx)
    );

    assign sel_addr  = gnt_idx ? bus.addr1 : bus.addr0;
    assign sel_wdata = gnt_idx ? bus.wdata1 : bus.wdata0;
    assign sel_we    = bus.we[gnt_idx];
    assign sel_oor   = 32'(sel_addr) >= DEPTH;

    // All outputs are registered, so each is set up on the edge that enters its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            idx_q        <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            wcnt_q       <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            load_q       <= 1'b0;
            ctrl_q       <= 1'b0;
            drive_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt != 2'b00) begin
                        state_q      <= StAccess;
                        last_grant_q <= gnt_idx;
                        idx_q        <= gnt_idx;
                        we_q         <= sel_we;
                        oor_q        <= sel_oor;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        wcnt_q       <= 4'd0;
                        busy_q       <= 1'b1;
                        ctrl_q       <= !sel_we && !sel_oor;
                        drive_q      <= sel_we && !sel_oor;
                        load_q       <= sel_we && !sel_oor && (WaitLast == 4'd0);
                    end
                end
                StAccess: begin
                    if (wcnt_q == WaitLast) begin
                        state_q <= StDone;
                        ctrl_q  <= 1'b0;
                        drive_q <= 1'b0;
                        load_q  <= 1'b0;
                        ack_q   <= idx_q ? 2'b10 : 2'b01;
                        err_q   <= oor_q;
                        if (oor_q) begin
                            rdata_q <= '0;
                        end else if (!we_q) begin
                            rdata_q <= mem_bus;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                        // Single write edge: strobe only in the last ACCESS cycle.
                        load_q <= drive_q && ((wcnt_q + 4'd1) == WaitLast);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ack_q   <= 2'b00;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_load  = load_q;
    assign mem_ctrl  = ctrl_q;
    assign mem_bus   = drive_q ? wdata_q : {DataWidth{1'bz}};
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule
